// File: rtl/rs_issue_if.sv
// Signal bundle for the rs_issue reservation station: allocation port, two CDB
// broadcast buses, the issue handshake and the status outputs.
interface rs_issue_if #(
  parameter int RS_SIZE = 8,
  parameter int TAG_W   = 4,
  parameter int WORD_W  = 32,
  parameter int CTRL_W  = 16
);
  localparam int ID_W = $clog2(RS_SIZE);

  logic                flush;
  logic                alloc_valid;
  logic [ID_W-1:0]     alloc_id;
  logic [TAG_W-1:0]    alloc_tag;
  logic [TAG_W-1:0]    alloc_tag_1;
  logic [TAG_W-1:0]    alloc_tag_2;
  logic [WORD_W-1:0]   alloc_value_1;
  logic [WORD_W-1:0]   alloc_value_2;
  logic [WORD_W-1:0]   alloc_imm;
  logic [CTRL_W-1:0]   alloc_ctrl;
  logic [TAG_W-1:0]    cdb1_tag;
  logic [WORD_W-1:0]   cdb1_value;
  logic [TAG_W-1:0]    cdb2_tag;
  logic [WORD_W-1:0]   cdb2_value;
  logic                issue_valid;
  logic                issue_ready;
  logic [TAG_W-1:0]    issue_tag;
  logic [WORD_W-1:0]   issue_value_1;
  logic [WORD_W-1:0]   issue_value_2;
  logic [WORD_W-1:0]   issue_imm;
  logic [CTRL_W-1:0]   issue_ctrl;
  logic [RS_SIZE-1:0]  busy_vec;
  logic                alloc_err;

  modport master (
    output flush, alloc_valid, alloc_id, alloc_tag, alloc_tag_1, alloc_tag_2,
           alloc_value_1, alloc_value_2, alloc_imm, alloc_ctrl,
           cdb1_tag, cdb1_value, cdb2_tag, cdb2_value, issue_ready,
    input  issue_valid, issue_tag, issue_value_1, issue_value_2, issue_imm,
           issue_ctrl, busy_vec, alloc_err
  );

  modport slave (
    input  flush, alloc_valid, alloc_id, alloc_tag, alloc_tag_1, alloc_tag_2,
           alloc_value_1, alloc_value_2, alloc_imm, alloc_ctrl,
           cdb1_tag, cdb1_value, cdb2_tag, cdb2_value, issue_ready,
    output issue_valid, issue_tag, issue_value_1, issue_value_2, issue_imm,
           issue_ctrl, busy_vec, alloc_err
  );
endinterface

// File: rtl/rs_issue.sv
// Reservation station with CDB wakeup and oldest-ready-first issue selection.
// Operands wait on ROB tags; tag 0 means the value is already present.
module rs_issue #(
  parameter int RS_SIZE = 8,
  parameter int TAG_W   = 4,
  parameter int WORD_W  = 32,
  parameter int CTRL_W  = 16
) (
  input  logic      clk,
  input  logic      reset,
  rs_issue_if.slave bus
);
  localparam int ID_W  = $clog2(RS_SIZE);
  localparam int AGE_W = 4;
  localparam logic [AGE_W-1:0] AGE_MAX = 4'd15;
  localparam logic [TAG_W-1:0] TAG_NONE = {TAG_W{1'b0}};

  logic [RS_SIZE-1:0] r_busy;
  logic [TAG_W-1:0]   r_tag   [RS_SIZE];
  logic [TAG_W-1:0]   r_tag_1 [RS_SIZE];
  logic [TAG_W-1:0]   r_tag_2 [RS_SIZE];
  logic [WORD_W-1:0]  r_val_1 [RS_SIZE];
  logic [WORD_W-1:0]  r_val_2 [RS_SIZE];
  logic [WORD_W-1:0]  r_imm   [RS_SIZE];
  logic [CTRL_W-1:0]  r_ctrl  [RS_SIZE];
  logic [AGE_W-1:0]   r_age   [RS_SIZE];
  logic               r_alloc_err;

  logic [RS_SIZE-1:0] w_ready;
  logic               w_any;
  logic [ID_W-1:0]    w_sel;
  logic [AGE_W-1:0]   w_best_age;
  logic               w_fire;
  logic               w_alloc_ok;
  logic [TAG_W-1:0]   w_new_tag_1;
  logic [TAG_W-1:0]   w_new_tag_2;
  logic [WORD_W-1:0]  w_new_val_1;
  logic [WORD_W-1:0]  w_new_val_2;
  logic [TAG_W-1:0]   w_issue_tag;
  logic [WORD_W-1:0]  w_issue_val_1;
  logic [WORD_W-1:0]  w_issue_val_2;
  logic [WORD_W-1:0]  w_issue_imm;
  logic [CTRL_W-1:0]  w_issue_ctrl;

  function automatic logic tag_hit(input logic [TAG_W-1:0] t, input logic [TAG_W-1:0] b);
    return (t != TAG_NONE) && (t == b);
  endfunction

  function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
    return (a == AGE_MAX) ? AGE_MAX : a + 4'd1;
  endfunction

  // Readiness is taken from registered state only, giving one cycle of wakeup latency.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_ready[i] = r_busy[i] && (r_tag_1[i] == TAG_NONE) && (r_tag_2[i] == TAG_NONE);
    end
  end

  // Oldest ready entry wins; strict compare keeps the lowest index on ties.
  always_comb begin
    logic v_take;
    w_any      = 1'b0;
    w_sel      = {ID_W{1'b0}};
    w_best_age = {AGE_W{1'b0}};
    for (int i = 0; i < RS_SIZE; i++) begin
      v_take     = w_ready[i] && (!w_any || (r_age[i] > w_best_age));
      w_sel      = v_take ? ID_W'(i) : w_sel;
      w_best_age = v_take ? r_age[i] : w_best_age;
      w_any      = w_any | v_take;
    end
  end

  // Present the selected entry; all fields read as zero when nothing is ready.
  always_comb begin
    if (w_any) begin
      w_issue_tag   = r_tag[w_sel];
      w_issue_val_1 = r_val_1[w_sel];
      w_issue_val_2 = r_val_2[w_sel];
      w_issue_imm   = r_imm[w_sel];
      w_issue_ctrl  = r_ctrl[w_sel];
    end else begin
      w_issue_tag   = TAG_NONE;
      w_issue_val_1 = {WORD_W{1'b0}};
      w_issue_val_2 = {WORD_W{1'b0}};
      w_issue_imm   = {WORD_W{1'b0}};
      w_issue_ctrl  = {CTRL_W{1'b0}};
    end
  end

  // Operand capture at allocation: a same-cycle broadcast is not missed, cdb1 first.
  always_comb begin
    if (tag_hit(bus.alloc_tag_1, bus.cdb1_tag)) begin
      w_new_tag_1 = TAG_NONE;
      w_new_val_1 = bus.cdb1_value;
    end else if (tag_hit(bus.alloc_tag_1, bus.cdb2_tag)) begin
      w_new_tag_1 = TAG_NONE;
      w_new_val_1 = bus.cdb2_value;
    end else begin
      w_new_tag_1 = bus.alloc_tag_1;
      w_new_val_1 = bus.alloc_value_1;
    end
    if (tag_hit(bus.alloc_tag_2, bus.cdb1_tag)) begin
      w_new_tag_2 = TAG_NONE;
      w_new_val_2 = bus.cdb1_value;
    end else if (tag_hit(bus.alloc_tag_2, bus.cdb2_tag)) begin
      w_new_tag_2 = TAG_NONE;
      w_new_val_2 = bus.cdb2_value;
    end else begin
      w_new_tag_2 = bus.alloc_tag_2;
      w_new_val_2 = bus.alloc_value_2;
    end
  end

  assign w_fire     = w_any && bus.issue_ready;
  assign w_alloc_ok = bus.alloc_valid && !r_busy[bus.alloc_id];

  // Entry state: reset beats flush, flush beats alloc/issue/wakeup.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busy      <= {RS_SIZE{1'b0}};
      r_alloc_err <= 1'b0;
      for (int i = 0; i < RS_SIZE; i++) begin
        r_tag[i]   <= TAG_NONE;
        r_tag_1[i] <= TAG_NONE;
        r_tag_2[i] <= TAG_NONE;
        r_val_1[i] <= {WORD_W{1'b0}};
        r_val_2[i] <= {WORD_W{1'b0}};
        r_imm[i]   <= {WORD_W{1'b0}};
        r_ctrl[i]  <= {CTRL_W{1'b0}};
        r_age[i]   <= {AGE_W{1'b0}};
      end
    end else if (bus.flush) begin
      r_busy <= {RS_SIZE{1'b0}};
      for (int i = 0; i < RS_SIZE; i++) begin
        r_age[i] <= {AGE_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_busy[i]) begin
          r_age[i] <= age_inc(r_age[i]);
          if (tag_hit(r_tag_1[i], bus.cdb1_tag)) begin
            r_tag_1[i] <= TAG_NONE;
            r_val_1[i] <= bus.cdb1_value;
          end else if (tag_hit(r_tag_1[i], bus.cdb2_tag)) begin
            r_tag_1[i] <= TAG_NONE;
            r_val_1[i] <= bus.cdb2_value;
          end
          if (tag_hit(r_tag_2[i], bus.cdb1_tag)) begin
            r_tag_2[i] <= TAG_NONE;
            r_val_2[i] <= bus.cdb1_value;
          end else if (tag_hit(r_tag_2[i], bus.cdb2_tag)) begin
            r_tag_2[i] <= TAG_NONE;
            r_val_2[i] <= bus.cdb2_value;
          end
        end
        if (w_fire && (w_sel == ID_W'(i))) begin
          r_busy[i] <= 1'b0;
        end
        // An issuing slot is still busy here, so it cannot be reallocated this cycle.
        if (w_alloc_ok && (bus.alloc_id == ID_W'(i))) begin
          r_busy[i]  <= 1'b1;
          r_tag[i]   <= bus.alloc_tag;
          r_tag_1[i] <= w_new_tag_1;
          r_tag_2[i] <= w_new_tag_2;
          r_val_1[i] <= w_new_val_1;
          r_val_2[i] <= w_new_val_2;
          r_imm[i]   <= bus.alloc_imm;
          r_ctrl[i]  <= bus.alloc_ctrl;
          r_age[i]   <= {AGE_W{1'b0}};
        end
      end
      if (bus.alloc_valid && r_busy[bus.alloc_id]) begin
        r_alloc_err <= 1'b1;
      end
    end
  end

  assign bus.issue_valid   = w_any;
  assign bus.issue_tag     = w_issue_tag;
  assign bus.issue_value_1 = w_issue_val_1;
  assign bus.issue_value_2 = w_issue_val_2;
  assign bus.issue_imm     = w_issue_imm;
  assign bus.issue_ctrl    = w_issue_ctrl;
  assign bus.busy_vec      = r_busy;
  assign bus.alloc_err     = r_alloc_err;
endmodule
